// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, packet limits and the receive FSM encoding.
package noc_pkg;

    localparam int FLIT_W  = 32;
    localparam int SIZE_HI = 23;
    localparam int SIZE_LO = 21;
    localparam int DEST_HI = 31;
    localparam int DEST_LO = 24;
    localparam int MAX_PKT = 5;
    localparam int CAP_W   = 3;

    typedef enum logic [1:0] {
        RX_HEAD,
        RX_BODY,
        RX_DISCARD
    } rx_state_t;

    // Circular pointer increment; depth is not a power of two.
    function automatic logic [CAP_W-1:0] ptr_inc(input logic [CAP_W-1:0] p,
                                                 input logic [CAP_W-1:0] depth);
        return (p == depth - 3'd1) ? '0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/flit_ram.sv
// DEPTH x FLIT_W register array: one synchronous write port, one async read port.
module flit_ram
    import noc_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [CAP_W-1:0]  waddr,
    input  logic [FLIT_W-1:0] wdata,
    input  logic [CAP_W-1:0]  raddr,
    output logic [FLIT_W-1:0] rdata
);

    logic [FLIT_W-1:0] mem [DEPTH];

    // Cleared on reset so the show-ahead output reads zero when empty.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/flit_input_buffer.sv
// Router input port: stores incoming packets speculatively, commits whole packets,
// and presents committed flits show-ahead. Handshake: ready=1 means data_out is a
// committed flit; asserting next_signal while ready=1 pops it at the clock edge.
module flit_input_buffer
    import noc_pkg::*;
#(
    parameter int DEPTH   = 7,
    parameter int MAX_PKT = noc_pkg::MAX_PKT,
    parameter int SIZE_HI = noc_pkg::SIZE_HI,
    parameter int SIZE_LO = noc_pkg::SIZE_LO
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_in,
    input  logic        write_in,
    output logic [2:0]  capacity_out,
    output logic        ack_out,
    input  logic        next_signal,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        drop_err
);

    localparam logic [CAP_W-1:0] DEPTH_C = CAP_W'(DEPTH);
    localparam logic [CAP_W-1:0] MAX_C   = CAP_W'(MAX_PKT);

    rx_state_t        rx_state, rx_state_next;
    logic [CAP_W-1:0] remaining, remaining_next;
    logic [CAP_W-1:0] rd_ptr, wr_commit, wr_spec;
    logic [CAP_W-1:0] committed_flits, inflight, pkt_count, rd_remaining;
    logic [CAP_W-1:0] free, size, head_size, committed_next, pkt_next;
    logic             size_bad, store, commit, drop, rollback, pop, pop_last;

    assign size         = data_in[SIZE_HI:SIZE_LO];
    assign head_size    = data_out[SIZE_HI:SIZE_LO];
    assign size_bad     = (size == '0) || (size > MAX_C);
    assign free         = DEPTH_C - committed_flits - inflight;
    assign capacity_out = free;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_state  <= RX_HEAD;
            remaining <= '0;
        end else begin
            rx_state  <= rx_state_next;
            remaining <= remaining_next;
        end
    end

    always_comb begin
        rx_state_next  = rx_state;
        remaining_next = remaining;
        case (rx_state)
            RX_HEAD: begin
                if (write_in && !size_bad && size != 3'd1) begin
                    remaining_next = size - 3'd1;
                    rx_state_next  = (size > free) ? RX_DISCARD : RX_BODY;
                end
            end
            RX_BODY: begin
                if (write_in) begin
                    remaining_next = remaining - 3'd1;
                    if (remaining == 3'd1) rx_state_next = RX_HEAD;
                    else if (free == '0)   rx_state_next = RX_DISCARD;
                end
            end
            RX_DISCARD: begin
                if (write_in) begin
                    remaining_next = remaining - 3'd1;
                    if (remaining == 3'd1) rx_state_next = RX_HEAD;
                end
            end
            default: rx_state_next = RX_HEAD;
        endcase
    end

    always_comb begin
        store    = 1'b0;
        commit   = 1'b0;
        drop     = 1'b0;
        rollback = 1'b0;
        case (rx_state)
            RX_HEAD: begin
                if (write_in) begin
                    if (size_bad) begin
                        drop = 1'b1;
                    end else if (size > free) begin
                        drop = (size == 3'd1);
                    end else begin
                        store  = 1'b1;
                        commit = (size == 3'd1);
                    end
                end
            end
            RX_BODY: begin
                if (write_in) begin
                    if (free == '0) begin
                        rollback = 1'b1;
                        drop     = (remaining == 3'd1);
                    end else begin
                        store  = 1'b1;
                        commit = (remaining == 3'd1);
                    end
                end
            end
            RX_DISCARD: drop = write_in && (remaining == 3'd1);
            default: ;
        endcase
    end

    // Read side re-derives packet boundaries from the head flit it is popping.
    assign pop      = next_signal && (committed_flits != '0);
    assign pop_last = (rd_remaining == '0) ? (head_size == 3'd1) : (rd_remaining == 3'd1);

    assign committed_next = committed_flits - CAP_W'(pop) + (commit ? inflight + 3'd1 : '0);
    assign pkt_next       = pkt_count + CAP_W'(commit) - CAP_W'(pop && pop_last);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr          <= '0;
            wr_commit       <= '0;
            wr_spec         <= '0;
            committed_flits <= '0;
            inflight        <= '0;
            pkt_count       <= '0;
            rd_remaining    <= '0;
            ack_out         <= 1'b0;
            drop_err        <= 1'b0;
            ready           <= 1'b0;
        end else begin
            if (rollback)   wr_spec <= wr_commit;
            else if (store) wr_spec <= ptr_inc(wr_spec, DEPTH_C);
            if (commit)     wr_commit <= ptr_inc(wr_spec, DEPTH_C);
            if (rollback || commit) inflight <= '0;
            else if (store)         inflight <= inflight + 3'd1;
            if (pop) begin
                rd_ptr       <= ptr_inc(rd_ptr, DEPTH_C);
                rd_remaining <= (rd_remaining == '0) ? head_size - 3'd1 : rd_remaining - 3'd1;
            end
            committed_flits <= committed_next;
            pkt_count       <= pkt_next;
            ack_out         <= commit;
            drop_err        <= drop;
            ready           <= (pkt_next != '0);
        end
    end

    flit_ram #(.DEPTH(DEPTH)) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (store),
        .waddr   (wr_spec),
        .wdata   (data_in),
        .raddr   (rd_ptr),
        .rdata   (data_out)
    );

endmodule

// File: tb/tb_flit_input_buffer.sv
// Bench for flit_input_buffer: directed packets, a popped-flit scoreboard and
// cycle-level checks of capacity, ack and drop pulses.
module tb_flit_input_buffer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] data_in;
    logic        write_in;
    logic [2:0]  capacity_out;
    logic        ack_out;
    logic        next_signal;
    logic [31:0] data_out;
    logic        ready;
    logic        drop_err;

    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    flit_input_buffer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .write_in     (write_in),
        .capacity_out (capacity_out),
        .ack_out      (ack_out),
        .next_signal  (next_signal),
        .data_out     (data_out),
        .ready        (ready),
        .drop_err     (drop_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_head(input logic [7:0] dest, input logic [2:0] size,
                                            input logic [20:0] tag);
        return {dest, size, tag};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic tick(input logic wr, input logic [31:0] d, input logic nx);
        write_in    = wr;
        data_in     = d;
        next_signal = nx;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: every accepted pop must match the next expected flit.
    always @(negedge clock) begin
        if (reset_n && next_signal && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h with empty scoreboard", data_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h at %0t", data_out, e, $time);
                end
            end
        end
    end

    initial begin
        logic [31:0] h;
        reset_n     = 1'b0;
        write_in    = 1'b0;
        data_in     = '0;
        next_signal = 1'b0;
        idle();
        idle();
        reset_n = 1'b1;
        chk("rst_cap", capacity_out, 7);
        chk("rst_ack", ack_out, 0);
        chk("rst_ready", ready, 0);
        chk("rst_drop", drop_err, 0);
        chk("rst_data", data_out, 0);

        // 3-flit packet accepted and committed
        h = mk_head(8'h11, 3'd3, 21'h0a0a0);
        exp_q.push_back(h); exp_q.push_back(32'hb0d1_0001); exp_q.push_back(32'hb0d1_0002);
        tick(1'b1, h, 1'b0);            chk("t1_cap6", capacity_out, 6); chk("t1_ready0", ready, 0);
        tick(1'b1, 32'hb0d1_0001, 1'b0); chk("t1_cap5", capacity_out, 5); chk("t1_noack", ack_out, 0);
        tick(1'b1, 32'hb0d1_0002, 1'b0); chk("t1_cap4", capacity_out, 4);
        chk("t1_ack", ack_out, 1); chk("t1_ready", ready, 1); chk("t1_head", data_out, h);
        idle();                          chk("t1_ack_pulse", ack_out, 0);

        // drain it
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);         chk("t2_ready_mid", ready, 1);
        tick(1'b0, 32'h0, 1'b1);         chk("t2_ready0", ready, 0); chk("t2_cap7", capacity_out, 7);
        idle();

        // 5 committed, then an oversize-for-space packet is discarded
        h = mk_head(8'h22, 3'd5, 21'h1);
        exp_q.push_back(h);
        tick(1'b1, h, 1'b0);
        for (int i = 1; i < 5; i++) begin
            exp_q.push_back(32'hc000_0000 + i);
            tick(1'b1, 32'hc000_0000 + i, 1'b0);
        end
        chk("t3_ack", ack_out, 1); chk("t3_cap2", capacity_out, 2);
        tick(1'b1, mk_head(8'h33, 3'd3, 21'h2), 1'b0); chk("t3_dcap_a", capacity_out, 2);
        chk("t3_nodrop_a", drop_err, 0);
        tick(1'b1, 32'hdead_0001, 1'b0);  chk("t3_dcap_b", capacity_out, 2);
        tick(1'b1, 32'hdead_0002, 1'b0);  chk("t3_drop", drop_err, 1); chk("t3_noack", ack_out, 0);
        chk("t3_cap_after", capacity_out, 2);
        idle();                           chk("t3_drop_pulse", drop_err, 0);
        for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b1);
        chk("t3_cap7", capacity_out, 7); chk("t3_ready0", ready, 0);
        idle();

        // illegal sizes
        tick(1'b1, mk_head(8'h44, 3'd0, 21'h3), 1'b0);
        chk("t4_drop0", drop_err, 1); chk("t4_cap0", capacity_out, 7);
        tick(1'b1, mk_head(8'h44, 3'd6, 21'h4), 1'b0);
        chk("t4_drop6", drop_err, 1); chk("t4_cap6", capacity_out, 7); chk("t4_ready", ready, 0);
        idle();                           chk("t4_drop_clr", drop_err, 0);

        // push/pop concurrency and pointer wrap (slots 1..4, then 5,6,0)
        h = mk_head(8'h55, 3'd4, 21'h5);
        exp_q.push_back(h);
        tick(1'b1, h, 1'b0);
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back(32'he000_0000 + i);
            tick(1'b1, 32'he000_0000 + i, 1'b0);
        end
        chk("t5_cap3", capacity_out, 3);
        h = mk_head(8'h66, 3'd3, 21'h6);
        exp_q.push_back(h); exp_q.push_back(32'hf000_0001); exp_q.push_back(32'hf000_0002);
        tick(1'b1, h, 1'b1);              chk("t5_pp_a", capacity_out, 3);
        tick(1'b1, 32'hf000_0001, 1'b1);  chk("t5_pp_b", capacity_out, 3);
        tick(1'b1, 32'hf000_0002, 1'b1);  chk("t5_pp_c", capacity_out, 3); chk("t5_ack", ack_out, 1);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b1);
        chk("t5_cap7", capacity_out, 7); chk("t5_ready0", ready, 0);
        // pop with nothing committed is ignored
        tick(1'b0, 32'h0, 1'b1);          chk("t5_empty_pop", capacity_out, 7);
        idle();

        // reset mid-packet, then a clean packet
        tick(1'b1, mk_head(8'h77, 3'd5, 21'h7), 1'b0);
        tick(1'b1, 32'h7777_0001, 1'b0);
        reset_n = 1'b0;
        idle();
        chk("t6_cap7", capacity_out, 7); chk("t6_ready0", ready, 0);
        chk("t6_noack", ack_out, 0); chk("t6_nodrop", drop_err, 0);
        reset_n = 1'b1;
        h = mk_head(8'h88, 3'd2, 21'h8);
        exp_q.push_back(h); exp_q.push_back(32'h8888_0001);
        tick(1'b1, h, 1'b0);
        tick(1'b1, 32'h8888_0001, 1'b0);
        chk("t6_ack", ack_out, 1); chk("t6_cap5", capacity_out, 5); chk("t6_ready", ready, 1);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        idle();
        chk("t6_cap_end", capacity_out, 7);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flit_input_buffer.md
Name: flit_input_buffer

Overview:
- Per-port input stage of the mesh router. Five instances sit between the neighbouring routers' output links and the router's arbitration/forwarding core.
- Accepts 32-bit flits from the link, stores them in a circular FIFO and advertises free space back to the sender.
- Commits a packet only once all of its flits have arrived, then acknowledges it.
- Presents committed flits show-ahead to the router core, which pops them one per cycle.

Parameters:
- DEPTH, 7, flit slots in the FIFO; max 7 so that free space fits a 3-bit capacity field.
- MAX_PKT, 5, largest legal packet size in flits.
- SIZE_HI, 23, MSB of the head-flit size field.
- SIZE_LO, 21, LSB of the head-flit size field.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- data_in  in  32  flit from the upstream link.
- write_in  in  1  data_in valid this cycle.
- capacity_out  out  3  free slots, i.e. DEPTH minus (committed + in-flight flits).
- ack_out  out  1  one-cycle pulse when a packet is committed.
- next_signal  in  1  pop request from the router core.
- data_out  out  32  flit at the read pointer (show-ahead).
- ready  out  1  at least one committed packet is stored.
- drop_err  out  1  one-cycle pulse when a packet is discarded.

Behaviour:
- Interface: one clock, `clock`. Reset `reset_n` is synchronous and active-low.
- Reset state:
  - All pointers and counters are 0; capacity_out = DEPTH.
  - ack_out, ready and drop_err are 0; data_out is 0.
  - Any in-flight packet is discarded silently: no ack, no drop_err.
- Pointers:
  - rd_ptr, wr_commit (end of the last committed packet) and wr_spec (next write slot).
  - All pointers wrap modulo DEPTH.
- Write path:
  - A flit is received when write_in=1. A receive FSM tracks packet boundaries.
  - RX_HEAD:
    - On receipt, size = data_in[SIZE_HI:SIZE_LO].
    - If size == 0 or size > MAX_PKT, the flit is not stored. drop_err pulses the next cycle and the FSM stays in RX_HEAD.
    - Otherwise, if size > free space, the whole packet is rejected: go to RX_DISCARD with remaining = size-1. If size == 1, drop_err pulses and the FSM stays in RX_HEAD.
    - Otherwise the flit is stored at wr_spec, remaining = size-1, and the FSM goes to RX_BODY. If size == 1, commit immediately instead.
  - RX_BODY:
    - Each flit is stored and remaining is decremented.
    - When remaining reaches 0, commit: wr_commit = wr_spec, committed packet count +1, ack_out = 1 on the next cycle, return to RX_HEAD.
    - A write that finds the FIFO full is an overflow: roll back wr_spec = wr_commit, go to RX_DISCARD.
  - RX_DISCARD:
    - Incoming flits are ignored until the remaining count is exhausted.
    - Then drop_err pulses once and the FSM returns to RX_HEAD.
    - ack stays low, which the sender treats as "retransmit".
- Read path:
  - data_out is combinational from mem[rd_ptr].
  - Only committed flits are poppable.
  - next_signal=1 with committed flits > 0 advances rd_ptr by 1.
  - Per-packet flit tracking on the read side decrements the committed packet count when the last flit of a packet is popped.
  - A pop with no committed flits is ignored.
  - ready is registered: (committed packets > 0) after this cycle's update.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A commit and a pop of a different packet's last flit in the same cycle leave the packet count unchanged.
  - A pop never overtakes wr_commit.
- Latency: a flit written in cycle N is visible on data_out no earlier than the cycle after its packet commits.

Decomposition:
- Shared package `noc_pkg`:
  - FLIT_W = 32.
  - Head-flit field indices: size [23:21], dest [31:24].
  - MAX_PKT and the capacity width.
  - rx_state_t enum {RX_HEAD, RX_BODY, RX_DISCARD}.
  - Reused by the router core and the routing function.
- One natural sub-module, `flit_ram`: a DEPTH x 32 register array with a write port and an async read port.

Test Plan:
1. After reset, send a 3-flit packet (head size=3), one flit per cycle → capacity_out goes 7→6→5→4; ack_out pulses 1 cycle after the third flit; ready=1; data_out = head.
2. Pop 3 flits → data_out steps through the flits in order; ready falls after the third pop; capacity_out returns to 7.
3. With 5 flits already committed, send a head with size=3 → packet discarded; capacity_out stays 2; drop_err pulses after the third flit; no ack.
4. Send a head with size=0, then a head with size=6 → neither is stored; drop_err pulses for each; capacity_out = 7 throughout.
5. Push and pop in the same cycle while 4 flits are committed → capacity_out is unchanged; flit order is preserved across the pointer wrap at slot 6→0.
6. Assert reset_n=0 after 2 of 5 flits → the next cycle shows capacity_out = 7, ready = 0, no ack; a subsequent clean packet is accepted normally.
